// File: rtl/serial_bit_source.sv
// Parallel-to-serial bit source: a one-entry holding buffer feeds a shifter that
// emits one bit per enabled clock, so back-to-back words stream without gaps.
//
// state | meaning
// IDLE  | cnt == 0, no bit in flight; a held word is launched on the next enabled edge
// SHIFT | cnt >  0, cnt bits of the current word remain in shreg
module serial_bit_source #(
  parameter int WIDTH      = 8,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             en,
  output logic             x_out,
  output logic             x_valid,
  output logic             frame_done,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [WIDTH-1:0] hold;
  logic [WIDTH-1:0] shreg;
  logic             hold_valid;
  logic [CW-1:0]    cnt;

  logic             hold_head;
  logic             shreg_head;
  logic [WIDTH-1:0] hold_rest;
  logic [WIDTH-1:0] shreg_rest;

  // The emit end is the MSB or LSB; shifting is logical toward that end.
  always_comb begin
    hold_head  = MSB_FIRST ? hold[WIDTH-1]  : hold[0];
    shreg_head = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];
    hold_rest  = MSB_FIRST ? (hold << 1)    : (hold >> 1);
    shreg_rest = MSB_FIRST ? (shreg << 1)   : (shreg >> 1);
  end

  assign in_ready = !hold_valid;
  assign busy     = hold_valid || (cnt != '0) || x_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold       <= '0;
      hold_valid <= 1'b0;
      shreg      <= '0;
      cnt        <= '0;
      x_out      <= IDLE_LEVEL;
      x_valid    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      // Accept cannot collide with the drain below: hold_valid gates in_ready.
      if (in_valid && !hold_valid) begin
        hold       <= in_data;
        hold_valid <= 1'b1;
      end

      if (en) begin
        frame_done <= 1'b0;
        if (cnt != '0) begin
          x_out      <= shreg_head;
          x_valid    <= 1'b1;
          shreg      <= shreg_rest;
          cnt        <= cnt - ONE;
          frame_done <= (cnt == ONE);
        end else if (hold_valid) begin
          x_out      <= hold_head;
          x_valid    <= 1'b1;
          shreg      <= hold_rest;
          cnt        <= LAST;
          hold_valid <= 1'b0;
        end else begin
          x_out   <= IDLE_LEVEL;
          x_valid <= 1'b0;
        end
      end else begin
        x_valid    <= 1'b0;
        frame_done <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_serial_bit_source.sv
// Directed bench for serial_bit_source: an MSB-first and an LSB-first instance,
// table-driven single words plus hand sequences for reset, stall and streaming.
module tb_serial_bit_source;

  logic clk;
  logic rst;
  logic en;

  logic [7:0] d1, d2;
  logic v1, v2;
  logic r1, r2, xo1, xo2, xv1, xv2, fd1, fd2, b1, b2;

  int checks;
  int failures;

  serial_bit_source #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut_msb (
    .clk(clk), .rst(rst), .in_data(d1), .in_valid(v1), .in_ready(r1), .en(en),
    .x_out(xo1), .x_valid(xv1), .frame_done(fd1), .busy(b1)
  );

  serial_bit_source #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) dut_lsb (
    .clk(clk), .rst(rst), .in_data(d2), .in_valid(v2), .in_ready(r2), .en(en),
    .x_out(xo2), .x_valid(xv2), .frame_done(fd2), .busy(b2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit         lsb;
    logic [7:0] data;
    logic [7:0] exp;   // expected bits in emission order, exp[7] first
  } vec_t;

  vec_t tbl[6];

  logic sxv[0:18];
  logic sxo[0:18];
  logic sfd[0:18];
  logic srd[0:18];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic run_word(input bit lsb, input logic [7:0] w, input logic [7:0] ex);
    if (lsb) begin d2 = w; v2 = 1'b1; end
    else     begin d1 = w; v1 = 1'b1; end
    step();
    v1 = 1'b0;
    v2 = 1'b0;
    chk($sformatf("ready_after_accept_%h", w), lsb ? r2 : r1, 0);
    for (int i = 0; i < 8; i++) begin
      step();
      chk($sformatf("bit%0d_%h", i, w), lsb ? xo2 : xo1, ex[7-i]);
      chk($sformatf("xvalid%0d_%h", i, w), lsb ? xv2 : xv1, 1);
      chk($sformatf("fdone%0d_%h", i, w), lsb ? fd2 : fd1, (i == 7) ? 1 : 0);
    end
    step();
    chk($sformatf("idle_xvalid_%h", w), lsb ? xv2 : xv1, 0);
    chk($sformatf("idle_xout_%h", w), lsb ? xo2 : xo1, 0);
    chk($sformatf("idle_busy_%h", w), lsb ? b2 : b1, 0);
  endtask

  // Two words offered back-to-back on the MSB instance; samples k = edges after accept.
  task automatic stream2(input logic [7:0] w0, input logic [7:0] w1);
    d1 = w0;
    v1 = 1'b1;
    step();
    srd[0] = r1; sxv[0] = xv1; sxo[0] = xo1; sfd[0] = fd1;
    d1 = w1;
    for (int k = 1; k <= 18; k++) begin
      step();
      if (k == 2) v1 = 1'b0;
      srd[k] = r1; sxv[k] = xv1; sxo[k] = xo1; sfd[k] = fd1;
    end
  endtask

  initial begin
    logic [15:0] chain_exp;
    int nvalid;
    int ones;
    int runs;
    int zpos0;
    int zpos1;

    checks   = 0;
    failures = 0;
    rst = 1'b0;
    en  = 1'b1;
    d1 = '0; d2 = '0; v1 = 1'b0; v2 = 1'b0;

    tbl[0] = '{lsb: 1'b0, data: 8'hE7, exp: 8'b1110_0111};
    tbl[1] = '{lsb: 1'b0, data: 8'h3C, exp: 8'b0011_1100};
    tbl[2] = '{lsb: 1'b0, data: 8'h36, exp: 8'b0011_0110};
    tbl[3] = '{lsb: 1'b1, data: 8'h01, exp: 8'b1000_0000};
    tbl[4] = '{lsb: 1'b1, data: 8'h80, exp: 8'b0000_0001};
    tbl[5] = '{lsb: 1'b1, data: 8'h36, exp: 8'b0110_1100};

    #12;
    chk("rst_xout", xo1, 0);
    chk("rst_xvalid", xv1, 0);
    chk("rst_fdone", fd1, 0);
    chk("rst_ready", r1, 1);
    chk("rst_busy", b1, 0);
    chk("rst_ready_lsb", r2, 1);
    chk("rst_busy_lsb", b2, 0);
    #11;
    rst = 1'b1;
    step();
    chk("post_rst_ready", r1, 1);
    chk("post_rst_busy", b1, 0);

    for (int t = 0; t < 6; t++)
      run_word(tbl[t].lsb, tbl[t].data, tbl[t].exp);

    // Stall: en low for three edges after the third bit of A5.
    d1 = 8'hA5; v1 = 1'b1;
    step();
    v1 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("stall_pre_bit%0d", i), xo1, (i == 1) ? 0 : 1);
    end
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("stall_xvalid%0d", i), xv1, 0);
      chk($sformatf("stall_xout%0d", i), xo1, 1);
      chk($sformatf("stall_fdone%0d", i), fd1, 0);
      chk($sformatf("stall_busy%0d", i), b1, 1);
    end
    en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      logic [4:0] rest;
      rest = 5'b00101;
      step();
      chk($sformatf("stall_post_bit%0d", i), xo1, rest[4-i]);
      chk($sformatf("stall_post_xvalid%0d", i), xv1, 1);
      chk($sformatf("stall_post_fdone%0d", i), fd1, (i == 4) ? 1 : 0);
    end
    step();
    chk("stall_end_xvalid", xv1, 0);

    // Back-to-back FF then 00.
    stream2(8'hFF, 8'h00);
    chk("b2b_ready_k0", srd[0], 0);
    for (int k = 1; k <= 17; k++) begin
      chk($sformatf("b2b_xvalid_k%0d", k), sxv[k], (k <= 16) ? 1 : 0);
      chk($sformatf("b2b_fdone_k%0d", k), sfd[k], (k == 8 || k == 16) ? 1 : 0);
      chk($sformatf("b2b_ready_k%0d", k), srd[k], (k == 1 || k >= 9) ? 1 : 0);
      if (k <= 16) chk($sformatf("b2b_xout_k%0d", k), sxo[k], (k <= 8) ? 1 : 0);
    end

    // Chained E0 then 07 through a consecutive-ones (three) detector model.
    stream2(8'hE0, 8'h07);
    chain_exp = 16'b1110_0000_0000_0111;
    nvalid = 0; ones = 0; runs = 0; zpos0 = -1; zpos1 = -1;
    for (int k = 1; k <= 16; k++) begin
      chk($sformatf("chain_xout_k%0d", k), sxo[k], chain_exp[16-k]);
      if (sxv[k]) begin
        nvalid++;
        if (sxo[k]) begin
          ones++;
          if (ones == 3) begin
            runs++;
            if (zpos0 < 0) zpos0 = k; else zpos1 = k;
          end
        end else ones = 0;
      end
    end
    chk("chain_contiguous", nvalid, 16);
    chk("chain_runs", runs, 2);
    chk("chain_z0_pos", zpos0, 3);
    chk("chain_z1_pos", zpos1, 16);
    chk("chain_end_xvalid", sxv[17], 0);

    // Reset mid-word with a second word held: both discarded.
    d1 = 8'hE7; v1 = 1'b1;
    step();
    v1 = 1'b0;
    step(); step(); step();
    d1 = 8'h3C; v1 = 1'b1;
    step();
    v1 = 1'b0;
    chk("midrst_pre_ready", r1, 0);
    #2;
    rst = 1'b0;
    #1;
    chk("midrst_xout", xo1, 0);
    chk("midrst_xvalid", xv1, 0);
    chk("midrst_fdone", fd1, 0);
    chk("midrst_ready", r1, 1);
    chk("midrst_busy", b1, 0);
    #4;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("midrst_discard_xvalid%0d", i), xv1, 0);
      chk($sformatf("midrst_discard_fdone%0d", i), fd1, 0);
    end
    run_word(1'b0, 8'h5A, 8'b0101_1010);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
